// File: rtl/wave_capture_multi_if.sv
// Sample-stream and wave-RAM write bus between the sample source/RAM side (master)
// and the capture stage (slave).
interface wave_capture_multi_if #(
    parameter int SAMPLE_W = 16,
    parameter int OUT_W    = 8,
    parameter int ADDR_W   = 8
) ();
    logic                new_sample_ready;
    logic [SAMPLE_W-1:0] new_sample_in;
    logic                write_enable;
    logic [ADDR_W:0]     write_address;
    logic [OUT_W-1:0]    write_sample;

    modport master (
        output new_sample_ready, new_sample_in,
        input  write_enable, write_address, write_sample
    );

    modport slave (
        input  new_sample_ready, new_sample_in,
        output write_enable, write_address, write_sample
    );
endinterface

// File: rtl/wave_capture_multi.sv
// Triggered, decimated waveform capture into the inactive bank of a dual-bank wave RAM.
// Optional timeout-forced trigger is enabled by defining AUTO_TRIGGER_EN.
module wave_capture_multi #(
    parameter int SAMPLE_W     = 16,
    parameter int OUT_W        = 8,
    parameter int ADDR_W       = 8,
    parameter int DECIM_W      = 4,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset_n,
    wave_capture_multi_if.slave cap_if,
    input  logic [1:0]          trig_mode,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic [DECIM_W-1:0]  decim_ratio,
    input  logic                wave_display_idle,
    output logic                read_index,
    output logic                capture_done,
    output logic                armed,
    output logic                auto_triggered
);
    typedef enum logic [1:0] {ST_ARMED, ST_ACTIVE, ST_WAIT} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          sample_cnt_q, sample_cnt_d;
    logic [DECIM_W-1:0]         decim_cnt_q, decim_cnt_d;
    logic [DECIM_W-1:0]         ratio_q, ratio_d;
    logic signed [SAMPLE_W-1:0] prev_sample_q, prev_sample_d;
    logic                       prev_valid_q, prev_valid_d;
    logic                       read_index_q, read_index_d;
    logic                       capture_done_q, capture_done_d;

    logic signed [SAMPLE_W-1:0] cur_s, lvl_s;
    logic                       rise, fall, genuine_hit, trig_hit, wr_en;
    logic [OUT_W-1:0]           wr_data;

    assign cur_s = cap_if.new_sample_in;
    assign lvl_s = trig_level;

`ifdef AUTO_TRIGGER_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            auto_q, auto_d;
    logic            force_hit;

    assign force_hit = (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));
`endif

    // Stored sample is the top OUT_W bits with the sign bit flipped (offset binary).
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_wr_data
        if (gi == OUT_W - 1) begin : g_msb
            assign wr_data[gi] = ~cap_if.new_sample_in[SAMPLE_W-1];
        end else begin : g_lsb
            assign wr_data[gi] = cap_if.new_sample_in[SAMPLE_W-OUT_W+gi];
        end
    end

    always_comb begin
        rise = prev_valid_q && (prev_sample_q < lvl_s) && (cur_s >= lvl_s);
        fall = prev_valid_q && (prev_sample_q >= lvl_s) && (cur_s < lvl_s);
        case (trig_mode)
            2'b00:   genuine_hit = rise;
            2'b01:   genuine_hit = fall;
            2'b10:   genuine_hit = rise | fall;
            default: genuine_hit = 1'b1;
        endcase
`ifdef AUTO_TRIGGER_EN
        trig_hit = genuine_hit | force_hit;
`else
        trig_hit = genuine_hit;
`endif
    end

    always_comb begin
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
        decim_cnt_d    = decim_cnt_q;
        ratio_d        = ratio_q;
        prev_sample_d  = prev_sample_q;
        prev_valid_d   = prev_valid_q;
        read_index_d   = read_index_q;
        capture_done_d = 1'b0;
        wr_en          = 1'b0;
`ifdef AUTO_TRIGGER_EN
        to_cnt_d       = to_cnt_q;
        auto_d         = auto_q;
`endif

        if (cap_if.new_sample_ready) begin
            prev_sample_d = cur_s;
            prev_valid_d  = 1'b1;
        end

        case (state_q)
            ST_ARMED: begin
                if (cap_if.new_sample_ready) begin
`ifdef AUTO_TRIGGER_EN
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                    if (trig_hit) begin
                        wr_en        = 1'b1;
                        sample_cnt_d = ADDR_W'(1);
                        decim_cnt_d  = decim_ratio;
                        ratio_d      = decim_ratio;
                        state_d      = ST_ACTIVE;
`ifdef AUTO_TRIGGER_EN
                        auto_d       = ~genuine_hit;
`endif
                    end
                end
            end
            ST_ACTIVE: begin
                if (cap_if.new_sample_ready) begin
                    if (decim_cnt_q == '0) begin
                        wr_en       = 1'b1;
                        decim_cnt_d = ratio_q;
                        if (sample_cnt_q == {ADDR_W{1'b1}}) begin
                            sample_cnt_d   = '0;
                            state_d        = ST_WAIT;
                            capture_done_d = 1'b1;
                        end else begin
                            sample_cnt_d = sample_cnt_q + ADDR_W'(1);
                        end
                    end else begin
                        decim_cnt_d = decim_cnt_q - DECIM_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                // A sample arriving in the swap cycle is dropped: prev_valid is cleared.
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    sample_cnt_d = '0;
                    prev_valid_d = 1'b0;
                    state_d      = ST_ARMED;
`ifdef AUTO_TRIGGER_EN
                    to_cnt_d     = '0;
`endif
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_ARMED;
            sample_cnt_q   <= '0;
            decim_cnt_q    <= '0;
            ratio_q        <= '0;
            prev_sample_q  <= '0;
            prev_valid_q   <= 1'b0;
            read_index_q   <= 1'b0;
            capture_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_cnt_q   <= sample_cnt_d;
            decim_cnt_q    <= decim_cnt_d;
            ratio_q        <= ratio_d;
            prev_sample_q  <= prev_sample_d;
            prev_valid_q   <= prev_valid_d;
            read_index_q   <= read_index_d;
            capture_done_q <= capture_done_d;
        end
    end

`ifdef AUTO_TRIGGER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
            auto_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            auto_q   <= auto_d;
        end
    end

    assign auto_triggered = auto_q;
`else
    // No timeout path: the flag is constant low.
    assign auto_triggered = (AUTO_TIMEOUT < 0);
`endif

    assign cap_if.write_enable  = wr_en;
    assign cap_if.write_address = {~read_index_q, sample_cnt_q};
    assign cap_if.write_sample  = wr_data;
    assign read_index           = read_index_q;
    assign capture_done         = capture_done_q;
    assign armed                = (state_q == ST_ARMED);
endmodule

// File: tb/tb_wave_capture_multi.sv
// Directed table-driven bench for wave_capture_multi with hand-written capture sequences.
module tb_wave_capture_multi;
    localparam int SW = 16;
    localparam int OW = 8;
    localparam int AW = 8;
    localparam int DW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    trig_mode;
    logic [SW-1:0] trig_level;
    logic [DW-1:0] decim_ratio;
    logic          wave_display_idle;
    logic          read_index, capture_done, armed, auto_triggered;

    always #5 clk = ~clk;

    wave_capture_multi_if #(.SAMPLE_W(SW), .OUT_W(OW), .ADDR_W(AW)) wif ();

    wave_capture_multi #(
        .SAMPLE_W(SW), .OUT_W(OW), .ADDR_W(AW), .DECIM_W(DW), .AUTO_TIMEOUT(TO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cap_if           (wif.slave),
        .trig_mode        (trig_mode),
        .trig_level       (trig_level),
        .decim_ratio      (decim_ratio),
        .wave_display_idle(wave_display_idle),
        .read_index       (read_index),
        .capture_done     (capture_done),
        .armed            (armed),
        .auto_triggered   (auto_triggered)
    );

    typedef struct {
        logic [1:0]    mode;
        logic [SW-1:0] level;
        logic [DW-1:0] ratio;
        logic [SW-1:0] smp;
        logic          exp_we;
        logic [AW:0]   exp_addr;
        logic [OW-1:0] exp_data;
        logic          exp_armed;
    } vec_t;

    vec_t vt[9];

    int n_checks = 0;
    int n_pass   = 0;

    logic          we_c;
    logic [AW:0]   addr_c;
    logic [OW-1:0] data_c;

    function automatic vec_t mk(input logic [1:0] m, input logic [SW-1:0] lv, input logic [DW-1:0] r,
                                input logic [SW-1:0] s, input logic we, input logic [AW:0] a,
                                input logic [OW-1:0] d, input logic arm);
        vec_t v;
        v.mode = m; v.level = lv; v.ratio = r; v.smp = s;
        v.exp_we = we; v.exp_addr = a; v.exp_data = d; v.exp_armed = arm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: drive at negedge, capture combinational write bus just before posedge.
    task automatic cyc(input logic rdy, input logic [SW-1:0] s);
        @(negedge clk);
        wif.new_sample_ready = rdy;
        wif.new_sample_in    = s;
        #4;
        we_c   = wif.write_enable;
        addr_c = wif.write_address;
        data_c = wif.write_sample;
        @(posedge clk);
        #1;
        $display("txn rdy=%0b in=%h we=%0b addr=%h data=%h ri=%0b armed=%0b done=%0b auto=%0b",
                 rdy, s, we_c, addr_c, data_c, read_index, armed, capture_done, auto_triggered);
    endtask

    task automatic apply_vec(input int i);
        trig_mode   = vt[i].mode;
        trig_level  = vt[i].level;
        decim_ratio = vt[i].ratio;
        cyc(1'b1, vt[i].smp);
        check($sformatf("vec%0d_we", i), 32'(we_c), 32'(vt[i].exp_we));
        if (vt[i].exp_we) begin
            check($sformatf("vec%0d_addr", i), 32'(addr_c), 32'(vt[i].exp_addr));
            check($sformatf("vec%0d_data", i), 32'(data_c), 32'(vt[i].exp_data));
        end
        check($sformatf("vec%0d_armed", i), 32'(armed), 32'(vt[i].exp_armed));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        //          mode   level     ratio  sample    we    addr    data   armed
        vt[0] = mk(2'b00, 16'h0000, 4'd0, 16'h00C8, 1'b0, 9'h000, 8'h00, 1'b1); // first sample never triggers
        vt[1] = mk(2'b00, 16'h0000, 4'd0, 16'hFF9C, 1'b0, 9'h000, 8'h00, 1'b1); // falling, mode rising
        vt[2] = mk(2'b00, 16'h0000, 4'd0, 16'h0032, 1'b1, 9'h100, 8'h80, 1'b0); // -100 -> +50 rise
        vt[3] = mk(2'b01, 16'h1000, 4'd3, 16'h2000, 1'b0, 9'h000, 8'h00, 1'b1);
        vt[4] = mk(2'b01, 16'h1000, 4'd3, 16'h0800, 1'b1, 9'h000, 8'h88, 1'b0); // fall, bank 0
        vt[5] = mk(2'b00, 16'h1000, 4'd0, 16'h2000, 1'b0, 9'h000, 8'h00, 1'b1);
        vt[6] = mk(2'b00, 16'h1000, 4'd0, 16'h0800, 1'b0, 9'h000, 8'h00, 1'b1); // fall ignored in mode 00
        vt[7] = mk(2'b10, 16'h1000, 4'd0, 16'h1000, 1'b1, 9'h100, 8'h90, 1'b0); // either: rise to level
        vt[8] = mk(2'b11, 16'h0000, 4'd0, 16'h7FFF, 1'b1, 9'h000, 8'hFF, 1'b0); // immediate

        reset_n = 1'b0;
        wif.new_sample_ready = 1'b0;
        wif.new_sample_in = '0;
        trig_mode = 2'b00; trig_level = '0; decim_ratio = '0; wave_display_idle = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_read_index", 32'(read_index), 32'd0);
        check("rst_armed", 32'(armed), 32'd1);
        check("rst_capture_done", 32'(capture_done), 32'd0);
        check("rst_auto", 32'(auto_triggered), 32'd0);
        check("rst_we", 32'(wif.write_enable), 32'd0);

        // Capture 1: bank 1, ratio 0
        for (int i = 0; i < 3; i++) apply_vec(i);
        for (int k = 1; k < 256; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            cyc(1'b1, {kb, 8'h00});
            check("c1_we", 32'(we_c), 32'd1);
            check("c1_addr", 32'(addr_c), 32'h100 + 32'(k));
            check("c1_data", 32'(data_c), 32'(kb ^ 8'h80));
            check("c1_done", 32'(capture_done), 32'(k == 255));
        end
        for (int w = 0; w < 20; w++) begin
            cyc(1'b1, 16'h4000);
            check("wait_we", 32'(we_c), 32'd0);
            check("wait_read_index", 32'(read_index), 32'd0);
            check("wait_done", 32'(capture_done), 32'd0);
        end
        wave_display_idle = 1'b1;
        cyc(1'b0, 16'h0000);
        wave_display_idle = 1'b0;
        check("swap1_read_index", 32'(read_index), 32'd1);
        check("swap1_armed", 32'(armed), 32'd1);

        // Capture 2: bank 0, ratio 3 latched; live ratio changed mid-capture
        apply_vec(3);
        apply_vec(4);
        decim_ratio = 4'd0;
        wave_display_idle = 1'b1;
        for (int i = 1; i <= 1020; i++) begin
            logic [9:0] ib;
            ib = 10'(i);
            cyc(1'b1, {ib[9:2], 8'h00});
            check("c2_we", 32'(we_c), 32'(i % 4 == 0));
            if (i % 4 == 0) begin
                check("c2_addr", 32'(addr_c), 32'(i / 4));
                check("c2_data", 32'(data_c), 32'(ib[9:2] ^ 8'h80));
            end
            check("c2_done", 32'(capture_done), 32'(i == 1020));
        end
        cyc(1'b1, 16'h7000);
        check("swap2_drop_we", 32'(we_c), 32'd0);
        check("swap2_read_index", 32'(read_index), 32'd0);
        check("swap2_armed", 32'(armed), 32'd1);
        wave_display_idle = 1'b0;

        // Capture 3: mode 00 ignores falling stream, then mode 10 triggers
        for (int i = 5; i < 8; i++) apply_vec(i);
        for (int k = 1; k < 256; k++) begin
            cyc(1'b1, 16'h0100);
            check("c3_we", 32'(we_c), 32'd1);
            check("c3_addr", 32'(addr_c), 32'h100 + 32'(k));
        end
        wave_display_idle = 1'b1;
        cyc(1'b0, 16'h0000);
        wave_display_idle = 1'b0;
        check("swap3_read_index", 32'(read_index), 32'd1);

        // Immediate trigger then reset mid-capture
        apply_vec(8);
        cyc(1'b1, 16'h0000);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_read_index", 32'(read_index), 32'd0);
        check("midrst_armed", 32'(armed), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Timeout behaviour on a constant-zero input
        trig_mode = 2'b00; trig_level = '0; decim_ratio = '0; wave_display_idle = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 16'h0000);
`ifdef AUTO_TRIGGER_EN
            check("auto_we", 32'(we_c), 32'(i >= 16));
            if (i == 16) begin
                check("auto_addr", 32'(addr_c), 32'h100);
                check("auto_data", 32'(data_c), 32'h80);
            end
            check("auto_flag", 32'(auto_triggered), 32'(i >= 16));
            check("auto_armed", 32'(armed), 32'(i < 16));
`else
            check("noauto_we", 32'(we_c), 32'd0);
            check("noauto_flag", 32'(auto_triggered), 32'd0);
            check("noauto_armed", 32'(armed), 32'd1);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
